// File: rtl/switch_debounce_filter_if.sv
// Switch-side bundle for the debouncer: raw pins in, clean levels and edge pulses out.
// The filter itself is the slave; whatever drives the pins and consumes the pulses is the master.
interface switch_debounce_filter_if #(
  parameter int NUM_SWITCHES = 4
);

  logic [NUM_SWITCHES-1:0] i_Switch;
  logic [NUM_SWITCHES-1:0] o_Switch;
  logic [NUM_SWITCHES-1:0] o_Press;
  logic [NUM_SWITCHES-1:0] o_Release;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press,
    input  o_Release
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press,
    output o_Release
  );

endinterface

// File: rtl/switch_debounce_filter.sv
// Multi-channel switch debouncer: 2-flop synchroniser, per-channel bounce counter,
// registered clean level plus one-cycle press/release pulses.
module switch_debounce_filter #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  switch_debounce_filter_if.slave sw
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_SWITCHES-1:0] sync_meta;
  logic [NUM_SWITCHES-1:0] sync_q;
  logic [NUM_SWITCHES-1:0] stable_q;
  logic [NUM_SWITCHES-1:0] press_q;
  logic [NUM_SWITCHES-1:0] release_q;
  logic [CNT_W-1:0]        count_q [NUM_SWITCHES];

  logic [NUM_SWITCHES-1:0] stable_d;
  logic [NUM_SWITCHES-1:0] press_d;
  logic [NUM_SWITCHES-1:0] release_d;
  logic [CNT_W-1:0]        count_d [NUM_SWITCHES];

  // A level is accepted only after it has disagreed with the stored state for
  // DEBOUNCE_LIMIT consecutive edges; any agreement restarts the count from zero.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      count_d[n] = '0;
      if (sync_q[n] != stable_q[n]) begin
        if (count_q[n] == CNT_LAST) begin
          stable_d[n]  = sync_q[n];
          press_d[n]   = sync_q[n];
          release_d[n] = ~sync_q[n];
        end else begin
          count_d[n] = count_q[n] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        count_q[n] <= '0;
      end
    end else begin
      sync_meta <= sw.i_Switch;
      sync_q    <= sync_meta;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        count_q[n] <= count_d[n];
      end
    end
  end

  assign sw.o_Switch  = stable_q;
  assign sw.o_Press   = press_q;
  assign sw.o_Release = release_q;

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed bench for switch_debounce_filter with DEBOUNCE_LIMIT=4, so an accepted
// change shows up on the 6th edge counting the first sampling edge.
module tb_switch_debounce_filter;

  localparam int NSW   = 4;
  localparam int LIMIT = 4;

  logic i_Clk;
  logic i_Reset;

  int num_vectors;
  int num_miscompares;

  switch_debounce_filter_if #(.NUM_SWITCHES(NSW)) sw_if ();

  switch_debounce_filter #(
    .NUM_SWITCHES  (NSW),
    .DEBOUNCE_LIMIT(LIMIT)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .sw     (sw_if.slave)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic apply_stimulus(input logic rst, input logic [NSW-1:0] pins);
    i_Reset         = rst;
    sw_if.i_Switch  = pins;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [NSW-1:0] observed,
                              input logic [NSW-1:0] expected);
    num_vectors++;
    assert (observed === expected)
    else begin
      num_miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [NSW-1:0] exp_sw,
                           input logic [NSW-1:0] exp_press, input logic [NSW-1:0] exp_rel);
    check_output({tag, ".switch"},  sw_if.o_Switch,  exp_sw);
    check_output({tag, ".press"},   sw_if.o_Press,   exp_press);
    check_output({tag, ".release"}, sw_if.o_Release, exp_rel);
  endtask

  // Holds the current pins for five edges (no change expected), then checks the
  // acceptance edge and the edge after it where the pulse must drop again.
  task automatic expect_accept(input string tag, input logic [NSW-1:0] sw_before,
                               input logic [NSW-1:0] sw_after, input logic [NSW-1:0] exp_press,
                               input logic [NSW-1:0] exp_rel);
    for (int e = 1; e <= LIMIT + 1; e++) begin
      tick();
      check_all({tag, ".wait"}, sw_before, '0, '0);
    end
    tick();
    check_all({tag, ".accept"}, sw_after, exp_press, exp_rel);
    tick();
    check_all({tag, ".pulse_end"}, sw_after, '0, '0);
  endtask

  initial begin
    logic [NSW-1:0] pins;
    logic [NSW-1:0] exp_sw;
    logic [NSW-1:0] exp_press;

    num_vectors     = 0;
    num_miscompares = 0;

    $display("[TB] reset with all pins pressed");
    apply_stimulus(1'b1, 4'b1111);
    repeat (3) begin
      tick();
      check_all("reset_hold", 4'b0000, 4'b0000, 4'b0000);
    end
    apply_stimulus(1'b0, 4'b1111);
    expect_accept("reset_exit", 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    $display("[TB] release of channel 2");
    apply_stimulus(1'b0, 4'b1011);
    expect_accept("release_ch2", 4'b1111, 4'b1011, 4'b0000, 4'b0100);

    apply_stimulus(1'b0, 4'b0000);
    expect_accept("release_rest", 4'b1011, 4'b0000, 4'b0000, 4'b1011);

    $display("[TB] clean press on channel 0");
    apply_stimulus(1'b0, 4'b0001);
    expect_accept("press_ch0", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    repeat (3) begin
      tick();
      check_all("press_ch0.hold", 4'b0001, 4'b0000, 4'b0000);
    end

    apply_stimulus(1'b0, 4'b0000);
    expect_accept("release_ch0", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    $display("[TB] bounce on channel 0");
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(1'b0, 4'b0001);
      repeat (3) begin
        tick();
        check_all("bounce_high", 4'b0000, 4'b0000, 4'b0000);
      end
      apply_stimulus(1'b0, 4'b0000);
      repeat (2) begin
        tick();
        check_all("bounce_low", 4'b0000, 4'b0000, 4'b0000);
      end
    end
    apply_stimulus(1'b0, 4'b0001);
    expect_accept("bounce_settle", 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    $display("[TB] independent channels 1 and 3");
    // Edge c samples the pins set just before it; ch1 set before edge 10, ch3 before edge 12.
    pins = 4'b0001;
    for (int c = 0; c <= 20; c++) begin
      if (c == 10) pins = pins | 4'b0010;
      if (c == 12) pins = pins | 4'b1000;
      apply_stimulus(1'b0, pins);
      tick();
      exp_sw    = 4'b0001 | ((c >= 15) ? 4'b0010 : 4'b0000) | ((c >= 17) ? 4'b1000 : 4'b0000);
      exp_press = ((c == 15) ? 4'b0010 : 4'b0000) | ((c == 17) ? 4'b1000 : 4'b0000);
      check_all("independence", exp_sw, exp_press, 4'b0000);
    end

    apply_stimulus(1'b0, 4'b0000);
    expect_accept("release_all", 4'b1011, 4'b0000, 4'b0000, 4'b1011);

    $display("[TB] reset in the middle of a count");
    apply_stimulus(1'b0, 4'b0001);
    repeat (3) begin
      tick();
      check_all("midcount_pre", 4'b0000, 4'b0000, 4'b0000);
    end
    apply_stimulus(1'b1, 4'b0001);
    tick();
    check_all("midcount_reset", 4'b0000, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 4'b0001);
    expect_accept("midcount_after", 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
